// File: rtl/tohost_capture_arbiter.sv
// Round-robin arbiter sharing one BRAM-to-host write port between N_CH capture streams.
// Each channel fills its own 2**CH_AWIDTH-word region; start/abort sequence the run.
module tohost_capture_arbiter #(
  parameter int unsigned N_CH                 = 4,
  parameter int unsigned CH_AWIDTH            = 10,
  parameter int unsigned BRAMTOHOST_ADDRWIDTH = 32,
  parameter int unsigned BRAMTOHOST_DATAWIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [N_CH-1:0]                      s_valid,
  input  logic [N_CH*BRAMTOHOST_DATAWIDTH-1:0] s_data,
  output logic [N_CH-1:0]                      s_ready,
  output logic                                 bram_we,
  output logic [BRAMTOHOST_ADDRWIDTH-1:0]      bram_addr,
  output logic [BRAMTOHOST_DATAWIDTH-1:0]      bram_din,
  output logic [N_CH*(CH_AWIDTH+1)-1:0]        ch_count,
  output logic [N_CH-1:0]                      ch_done,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned ChW  = $clog2(N_CH);
  localparam int unsigned CntW = CH_AWIDTH + 1;
  localparam int unsigned DW   = BRAMTOHOST_DATAWIDTH;
  localparam int unsigned AW   = BRAMTOHOST_ADDRWIDTH;
  localparam logic [CntW-1:0] Full = CntW'(1) << CH_AWIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [ChW-1:0]     rr_q;
  logic [CntW-1:0]    cnt_q [N_CH];
  logic [N_CH-1:0]    full_q;

  logic               arm;
  logic [N_CH-1:0]    elig;
  logic [N_CH-1:0]    grant;
  logic               gnt_any;
  logic [ChW-1:0]     gnt_idx;
  logic [ChW-1:0]     cand;
  logic [DW-1:0]      gnt_data;
  logic [AW-1:0]      gnt_addr;

  // abort has priority over start in the same cycle.
  assign arm = start && !abort;

  // A restarting run takes no new word in its start cycle, so nothing is counted then cleared.
  assign elig = (state_q == StRun && !start) ? (s_valid & ~full_q) : '0;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    grant   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      cand = rr_q + ChW'(i);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    gnt_data = s_data[gnt_idx*DW +: DW];
    gnt_addr = '0;
    gnt_addr[CH_AWIDTH +: ChW]  = gnt_idx;
    gnt_addr[CH_AWIDTH-1:0]     = cnt_q[gnt_idx][CH_AWIDTH-1:0];
  end

  always_comb begin
    ch_count = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      ch_count[i*CntW +: CntW] = cnt_q[i];
    end
  end

  assign s_ready = grant;
  assign ch_done = full_q;
  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      full_q    <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      bram_we <= gnt_any;
      if (gnt_any) begin
        bram_addr <= gnt_addr;
        bram_din  <= gnt_data;
        rr_q      <= gnt_idx + ChW'(1);
      end
      if (arm) begin
        rr_q <= '0;
      end

      // The region pointer is the low bits of the count; a full channel is never granted again.
      for (int i = 0; i < int'(N_CH); i++) begin
        if (arm) begin
          cnt_q[i]  <= '0;
          full_q[i] <= 1'b0;
        end else if (grant[i]) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
          if (cnt_q[i] + CntW'(1) == Full) begin
            full_q[i] <= 1'b1;
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (arm) state_q <= StRun;
        end
        StRun: begin
          if (abort)        state_q <= StIdle;
          else if (start)   state_q <= StRun;
          else if (&full_q) state_q <= StDone;
        end
        StDone: begin
          if (abort)      state_q <= StIdle;
          else if (start) state_q <= StRun;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tohost_capture_arbiter.sv
// Directed bench: expected grants and writes are queued as stimulus is driven,
// then compared against s_ready and the registered BRAM write port.
module tb_tohost_capture_arbiter;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int ADW = 32;
  localparam int DW  = 64;
  localparam int CW  = AW + 1;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              start;
  logic              abort;
  logic [N-1:0]      s_valid;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_ready;
  logic              bram_we;
  logic [ADW-1:0]    bram_addr;
  logic [DW-1:0]     bram_din;
  logic [N*CW-1:0]   ch_count;
  logic [N-1:0]      ch_done;
  logic              busy;
  logic              done;

  tohost_capture_arbiter #(
    .N_CH                 (N),
    .CH_AWIDTH            (AW),
    .BRAMTOHOST_ADDRWIDTH (ADW),
    .BRAMTOHOST_DATAWIDTH (DW)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .ch_count  (ch_count),
    .ch_done   (ch_done),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_t;

  int  checks   = 0;
  int  failures = 0;
  int  run_id   = 0;
  int  widx [N];
  int  gq [$];
  wr_t wq [$];

  function automatic logic [DW-1:0] mkdata(input int c, input int k);
    return {16'hCAFE, 16'(run_id), 16'(c), 16'(k)};
  endfunction

  function automatic logic [ADW-1:0] mkaddr(input int c, input int k);
    return ADW'((c << AW) | k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    for (int c = 0; c < N; c++) s_data[c*DW +: DW] = mkdata(c, widx[c]);
  endtask

  task automatic mon();
    wr_t e;
    if (wq.size() > 0) begin
      e = wq.pop_front();
      chk("bram_we", 64'(bram_we), 64'd1);
      chk("bram_addr", 64'(bram_addr), 64'(e.addr));
      chk("bram_din", bram_din, e.data);
    end else begin
      chk("bram_we_idle", 64'(bram_we), 64'd0);
    end
  endtask

  // One clock: check ready before the edge, check the write port after it.
  task automatic tick();
    int           ec;
    logic [N-1:0] er;
    @(negedge clk);
    ec = (gq.size() > 0) ? gq.pop_front() : -1;
    er = '0;
    if (ec >= 0) er[ec] = 1'b1;
    chk("s_ready", 64'(s_ready), 64'(er));
    if (ec >= 0) begin
      wq.push_back('{addr: mkaddr(ec, widx[ec]), data: mkdata(ec, widx[ec])});
      widx[ec]++;
    end
    @(posedge clk);
    #1;
    mon();
    set_data();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_id++;
    for (int c = 0; c < N; c++) widx[c] = 0;
    set_data();
  endtask

  task automatic cnt_chk(input string tag, input int c, input int exp);
    chk(tag, 64'(ch_count[c*CW +: CW]), 64'(exp));
  endtask

  initial begin
    aresetn = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = '0;
    s_data  = '0;
    for (int c = 0; c < N; c++) widx[c] = 0;
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    chk("rst_bram_din", bram_din, 64'd0);
    chk("rst_ch_count", 64'(ch_count), 64'd0);
    chk("rst_ch_done", 64'(ch_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    set_data();

    // 1: single channel streams into addresses 0..3 and fills.
    do_start();
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    s_valid = 4'b0001;
    repeat (4) gq.push_back(0);
    repeat (6) tick();
    chk("t1_ch_done", 64'(ch_done), 64'h1);
    cnt_chk("t1_cnt0", 0, 4);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_done", 64'(done), 64'd0);

    // 2: all channels continuous -> 0,1,2,3 repeating; done after 16 writes.
    do_start();
    cnt_chk("t2_cnt0_cleared", 0, 0);
    s_valid = 4'b1111;
    for (int r = 0; r < 4; r++) for (int c = 0; c < N; c++) gq.push_back(c);
    repeat (16) tick();
    chk("t2_ch_done", 64'(ch_done), 64'hF);
    chk("t2_done_not_yet", 64'(done), 64'd0);
    tick();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    cnt_chk("t2_cnt2", 2, 4);

    // 3: one ch1 word leaves rr=2; then ch3 and ch1 alternate starting with ch3.
    do_start();
    s_valid = 4'b0010;
    gq.push_back(1);
    tick();
    s_valid = 4'b1010;
    gq = '{3, 1, 3, 1, 3, 1, 3};
    repeat (9) tick();
    chk("t3_ch_done", 64'(ch_done), 64'hA);
    chk("t3_busy", 64'(busy), 64'd1);
    cnt_chk("t3_cnt0", 0, 0);

    // 4: abort coincident with a ch0 handshake; the word still lands.
    s_valid = 4'b0001;
    abort   = 1'b1;
    gq.push_back(0);
    tick();
    abort = 1'b0;
    chk("t4_busy", 64'(busy), 64'd0);
    tick();
    cnt_chk("t4_cnt0", 0, 1);
    cnt_chk("t4_cnt1", 1, 4);
    chk("t4_ch_done", 64'(ch_done), 64'hA);
    chk("t4_done", 64'(done), 64'd0);

    // 5: start with abort is ignored; a later start runs to completion.
    s_valid = 4'b1111;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("t5_busy_idle", 64'(busy), 64'd0);
    cnt_chk("t5_cnt0_held", 0, 1);
    do_start();
    chk("t5_ch_count_cleared", 64'(ch_count), 64'd0);
    chk("t5_ch_done_cleared", 64'(ch_done), 64'd0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < N; c++) gq.push_back(c);
    repeat (16) tick();
    tick();
    chk("t5_done", 64'(done), 64'd1);

    // 6: asynchronous reset in the middle of a run.
    do_start();
    gq = '{0, 1};
    tick();
    tick();
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_bram_we", 64'(bram_we), 64'd0);
    chk("t6_bram_addr", 64'(bram_addr), 64'd0);
    chk("t6_bram_din", bram_din, 64'd0);
    chk("t6_ch_count", 64'(ch_count), 64'd0);
    chk("t6_ch_done", 64'(ch_done), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_s_ready", 64'(s_ready), 64'd0);
    #3;
    aresetn = 1'b1;
    repeat (3) tick();
    chk("t6_busy_after", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
